ras_predictor: RTL and testbench

//  Parametrised return-address stack for the fetch/branch-predict stage. Decodes JAL/JALR link

---
 rtl/ras_predictor.sv | 156 +++++++++++++++
 tb/tb_ras_predictor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_predictor.sv
// Return-address stack: decodes JAL/JALR link hints and pushes/pops return addresses in a circular buffer.
// Define RAS_CKPT_EN to build the checkpoint/restore logic used for mispredict repair.
module ras_predictor #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst,
    input  logic                  in_valid,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ckpt_save,
    input  logic                  in_ckpt_restore,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [PTR_W:0]        out_count,
    output logic                  out_overflow,
    output logic                  out_underflow
);

    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_POPPUSH} ras_op_e;

    localparam logic [6:0]       OPC_JALR = 7'b1100111;
    localparam logic [6:0]       OPC_JAL  = 7'b1101111;
    localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      tos, tos_nxt;
    logic [PTR_W:0]        count, count_nxt;
    logic                  ovf_nxt, udf_nxt;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_link, rs1_link, is_jump;
    ras_op_e               op;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

`ifdef RAS_CKPT_EN
    logic [PTR_W-1:0]      ck_tos;
    logic [PTR_W:0]        ck_count;
    logic [DATA_WIDTH-1:0] ck_top;
    logic                  do_restore;

    assign do_restore = in_ckpt_restore;

    // A save coinciding with a restore is dropped so the old checkpoint survives.
    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            ck_tos   <= '0;
            ck_count <= '0;
            ck_top   <= '0;
        end else if (in_ckpt_save && !in_ckpt_restore) begin
            ck_tos   <= tos;
            ck_count <= count;
            ck_top   <= mem[tos];
        end
    end
`else
    logic [PTR_W-1:0]      ck_tos;
    logic [PTR_W:0]        ck_count;
    logic [DATA_WIDTH-1:0] ck_top;
    logic                  do_restore;
    logic                  unused_ckpt;

    assign ck_tos      = '0;
    assign ck_count    = '0;
    assign ck_top      = '0;
    assign do_restore  = 1'b0;
    assign unused_ckpt = in_ckpt_save ^ in_ckpt_restore;
`endif

    // JAL has no rs1, so only JALR can see a link source.
    assign is_jump  = in_valid && (in_opcode == OPC_JAL || in_opcode == OPC_JALR);
    assign rd_link  = is_link(in_rd);
    assign rs1_link = (in_opcode == OPC_JALR) && is_link(in_rs1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        op = OP_NONE;
        if (is_jump) begin
            if (rd_link && !rs1_link)      op = OP_PUSH;
            else if (!rd_link && rs1_link) op = OP_POP;
            else if (rd_link && rs1_link)  op = (in_rd == in_rs1) ? OP_PUSH : OP_POPPUSH;
        end
        if (op == OP_POPPUSH && count == '0) op = OP_PUSH;
    end

    always_comb begin
        tos_nxt   = tos;
        count_nxt = count;
        ovf_nxt   = 1'b0;
        udf_nxt   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = tos;
        wr_data   = in_data;
        if (do_restore) begin
            tos_nxt   = ck_tos;
            count_nxt = ck_count;
            wr_en     = 1'b1;
            wr_addr   = ck_tos;
            wr_data   = ck_top;
        end else begin
            case (op)
                OP_PUSH: begin
                    tos_nxt = tos + PTR_ONE;
                    wr_en   = 1'b1;
                    wr_addr = tos + PTR_ONE;
                    if (count == FULL) ovf_nxt = 1'b1;
                    else               count_nxt = count + CNT_ONE;
                end
                OP_POP: begin
                    if (count != '0) begin
                        tos_nxt   = tos - PTR_ONE;
                        count_nxt = count - CNT_ONE;
                    end else begin
                        udf_nxt = 1'b1;
                    end
                end
                OP_POPPUSH: wr_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            tos           <= '0;
            count         <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            tos           <= tos_nxt;
            count         <= count_nxt;
            out_overflow  <= ovf_nxt;
            out_underflow <= udf_nxt;
        end
    end

    // NOTE: the entry array has no reset; count gates every read so stale contents are never visible.
    always_ff @(posedge in_Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign out_count = count;
    assign out_valid = (count != '0);
    assign out_data  = (count != '0) ? mem[tos] : '0;

endmodule

// File: tb/tb_ras_predictor.sv
// Scoreboard bench for ras_predictor: a driver pushes model predictions, a monitor pops and compares.
// Model follows the stack rules directly with integer arithmetic over a circular array.
module tb_ras_predictor;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [6:0]    opcode;
    logic [4:0]    rd, rs1;
    logic [DW-1:0] din;
    logic          save, restore;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic [PTR_W:0] dcount;
    logic          ovf, udf;

    ras_predictor #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .in_Clk(clk), .in_Rst(rst), .in_valid(valid), .in_opcode(opcode),
        .in_rd(rd), .in_rs1(rs1), .in_data(din),
        .in_ckpt_save(save), .in_ckpt_restore(restore),
        .out_data(dout), .out_valid(dvalid), .out_count(dcount),
        .out_overflow(ovf), .out_underflow(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        int            count;
        logic          ovf;
        logic          udf;
        string         tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_tos, m_count;
    int            c_tos, c_count;
    logic [DW-1:0] c_top;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Drives one cycle of stimulus and queues the state expected after the next rising edge.
    task automatic step(input bit r, input bit v, input logic [6:0] opc, input logic [4:0] d_rd,
                        input logic [4:0] d_rs1, input logic [DW-1:0] d, input bit sv, input bit rs,
                        input string tag);
        exp_t e;
        bit rl, sl, jump;
        int kind; // 0 none, 1 push, 2 pop, 3 pop-then-push
        @(negedge clk);
        rst = r; valid = v; opcode = opc; rd = d_rd; rs1 = d_rs1; din = d;
        save = sv; restore = rs;
        e.ovf = 1'b0;
        e.udf = 1'b0;
        if (r) begin
            m_tos = 0; m_count = 0;
            c_tos = 0; c_count = 0; c_top = '0;
        end else begin
            jump = v && (opc == JAL || opc == JALR);
            rl   = link(d_rd);
            sl   = (opc == JALR) && link(d_rs1);
            kind = 0;
            if (jump) begin
                if (rl && !sl)      kind = 1;
                else if (!rl && sl) kind = 2;
                else if (rl && sl)  kind = (d_rd == d_rs1) ? 1 : 3;
            end
            if (kind == 3 && m_count == 0) kind = 1;
`ifdef RAS_CKPT_EN
            if (rs) begin
                m_tos = c_tos;
                m_count = c_count;
                m_mem[c_tos] = c_top;
                kind = 0;
            end else if (sv) begin
                c_tos = m_tos; c_count = m_count; c_top = m_mem[m_tos];
            end
`endif
            case (kind)
                1: begin
                    m_tos = (m_tos + 1) % DEPTH;
                    m_mem[m_tos] = d;
                    if (m_count == DEPTH) e.ovf = 1'b1;
                    else m_count++;
                end
                2: begin
                    if (m_count > 0) begin
                        m_tos = (m_tos + DEPTH - 1) % DEPTH;
                        m_count--;
                    end else e.udf = 1'b1;
                end
                3: m_mem[m_tos] = d;
                default: ;
            endcase
        end
        e.count = m_count;
        e.valid = (m_count > 0);
        e.data  = (m_count > 0) ? m_mem[m_tos] : '0;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic push(input logic [DW-1:0] d, input string tag);
        step(0, 1, JAL, 5'd1, 5'd0, d, 0, 0, tag);
    endtask

    task automatic pop(input string tag);
        step(0, 1, JALR, 5'd0, 5'd1, '0, 0, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        step(1, 0, '0, '0, '0, '0, 0, 0, tag);
    endtask

    // Monitor: outputs are present every cycle, so each queued prediction matches one edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, ".data"},  dout, e.data);
                check({e.tag, ".valid"}, DW'(dvalid), DW'(e.valid));
                check({e.tag, ".count"}, DW'(dcount), DW'(e.count));
                check({e.tag, ".ovf"},   DW'(ovf), DW'(e.ovf));
                check({e.tag, ".udf"},   DW'(udf), DW'(e.udf));
            end
        end
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic [6:0] opc;
        rst = 1'b1; valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; din = '0;
        save = 1'b0; restore = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_tos = 0; m_count = 0; c_tos = 0; c_count = 0; c_top = '0;

        do_reset("rst0");
        do_reset("rst1");
        push(64'h100, "t1_push");

        push(64'h10, "t2_p10");
        push(64'h20, "t2_p20");
        push(64'h30, "t2_p30");
        pop("t2_pop1");
        pop("t2_pop2");

        do_reset("t3_rst");
        for (int i = 1; i <= 9; i++) push(DW'(i), $sformatf("t3_push%0d", i));
        pop("t3_after_ovf");
        for (int i = 0; i < 7; i++) pop($sformatf("t3_pop%0d", i));
        pop("t3_underflow");
        step(0, 0, '0, '0, '0, '0, 0, 0, "t3_idle");

        do_reset("t4_rst");
        push(64'hA, "t4_pA");
        push(64'hB, "t4_pB");
        step(0, 1, JALR, 5'd1, 5'd5, 64'hC, 0, 0, "t4_poppush");
        pop("t4_pop");

        do_reset("t5_rst");
        step(0, 0, '0, '0, '0, '0, 0, 1, "t5_restore_unsaved");
        push(64'hA, "t5_pA");
        push(64'hB, "t5_pB");
        step(0, 0, '0, '0, '0, '0, 1, 0, "t5_save");
        pop("t5_pop");
        push(64'hE, "t5_pE");
        step(0, 0, '0, '0, '0, '0, 0, 1, "t5_restore");
        step(0, 1, JAL, 5'd1, 5'd0, 64'hF, 1, 1, "t5_restore_push");

        step(0, 0, JAL, 5'd1, 5'd0, 64'h77, 0, 0, "t6_invalid");
        step(0, 1, ALU, 5'd1, 5'd0, 64'h78, 0, 0, "t6_alu");
        push(64'h79, "t6_push");
        do_reset("t6_mid_rst");

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 2))
                0: opc = JAL;
                1: opc = JALR;
                default: opc = ALU;
            endcase
            step($urandom_range(0, 60) == 0, $urandom_range(0, 4) != 0, opc,
                 pick_reg(), pick_reg(), {$urandom, $urandom},
                 $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, $sformatf("rnd%0d", n));
        end

        repeat (200) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
